// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss countdown timer: state encoding, digit limits
// and the BCD helpers used by the controller.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // Clamp a {tens,units} BCD byte into a displayable value.
    function automatic logic [7:0] bcd_sanitise(input logic [7:0] value,
                                                input logic [3:0] tens_max);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = value[7:4];
        units = value[3:0];
        if (units > DIGIT_MAX) units = DIGIT_MAX;
        if (tens > tens_max)   tens  = tens_max;
        return {tens, units};
    endfunction

    // One-second decrement of {min_tens,min_units,sec_tens,sec_units}.
    // Never called on 00:00, so the minutes tens digit cannot underflow.
    function automatic logic [15:0] bcd_decrement(input logic [15:0] mmss);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = mmss;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = DIGIT_MAX;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = SEC_TENS_MAX;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = DIGIT_MAX;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts while enabled, wraps at TICK_DIV-1 and strobes
// tick for that cycle. The count is held while disabled so a pause keeps the
// partial second.
module tick_gen #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Mm:ss countdown controller: load/run/pause/expiry sequencing around the 1 s
// prescaler, with the remaining time kept as four BCD digits.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] state,
    output logic       tick,
    output logic       done,
    output logic       alarm
);

    state_t      state_reg, state_next;
    logic [7:0]  min_reg, min_next;
    logic [7:0]  sec_reg, sec_next;
    logic        done_reg, done_next;
    logic        alarm_reg;
    logic [7:0]  load_min_s;
    logic [7:0]  load_sec_s;
    logic [15:0] dec_value;

    assign load_min_s = bcd_sanitise(load_min, DIGIT_MAX);
    assign load_sec_s = bcd_sanitise(load_sec, SEC_TENS_MAX);
    assign dec_value  = bcd_decrement({min_reg, sec_reg});

    // Prescaler is parked at zero in IDLE so a fresh start always gets a full second.
    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .en    (state_reg == ST_RUN),
        .clr   (clear || (state_reg == ST_IDLE)),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            min_reg   <= '0;
            sec_reg   <= '0;
            done_reg  <= 1'b0;
            alarm_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            min_reg   <= min_next;
            sec_reg   <= sec_next;
            done_reg  <= done_next;
            alarm_reg <= (state_next == ST_EXPIRED);
        end
    end

    always_comb begin
        state_next = state_reg;
        min_next   = min_reg;
        sec_next   = sec_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                min_next = load_min_s;
                sec_next = load_sec_s;
                if (!clear && !pause && start && ({load_min_s, load_sec_s} != 16'h0000))
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (clear) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    // Decrement is applied even when pause arrives on the same cycle.
                    {min_next, sec_next} = dec_value;
                    if (dec_value == 16'h0000) begin
                        state_next = ST_EXPIRED;
                        done_next  = 1'b1;
                    end else if (pause) begin
                        state_next = ST_PAUSE;
                    end
                end else if (pause) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clear)
                    state_next = ST_IDLE;
                else if (!pause && start)
                    state_next = ST_RUN;
            end
            ST_EXPIRED: begin
                if (clear)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign min_bcd = min_reg;
    assign sec_bcd = sec_reg;
    assign state   = state_reg;
    assign done    = done_reg;
    assign alarm   = alarm_reg;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICK_DIV=4; outputs sampled 1 time
// unit after each rising edge.
module tb_countdown_timer_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] state;
    logic       tick;
    logic       done;
    logic       alarm;

    int n_total = 0;
    int n_bad   = 0;

    countdown_timer_ctrl #(
        .TICK_DIV (4),
        .CNT_W    (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .load_min (load_min),
        .load_sec (load_sec),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .state    (state),
        .tick     (tick),
        .done     (done),
        .alarm    (alarm)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1; step(); pause = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        load_min = 8'h00; load_sec = 8'h00;

        // 1: reset
        step(); step();
        check_eq("rst_state", {14'd0, state}, 16'd0);
        reset = 1'b1;
        step(); step();
        check_eq("rst_state_rel", {14'd0, state}, 16'd0);
        check_eq("rst_min", {8'd0, min_bcd}, 16'h00);
        check_eq("rst_sec", {8'd0, sec_bcd}, 16'h00);
        check_eq("rst_done", {15'd0, done}, 16'd0);
        check_eq("rst_alarm", {15'd0, alarm}, 16'd0);

        // 2: 00:03 countdown to expiry
        load_sec = 8'h03;
        step();
        check_eq("t2_preview", {8'd0, sec_bcd}, 16'h03);
        pulse_start();
        check_eq("t2_run", {14'd0, state}, 16'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check_eq($sformatf("t2_tick_e%0d", k), {15'd0, tick},
                     {15'd0, ((k % 4) == 3) && (k < 12)});
            check_eq($sformatf("t2_sec_e%0d", k), {8'd0, sec_bcd}, 16'(3 - k / 4));
            check_eq($sformatf("t2_state_e%0d", k), {14'd0, state}, (k >= 12) ? 16'd3 : 16'd1);
            check_eq($sformatf("t2_done_e%0d", k), {15'd0, done}, {15'd0, k == 12});
        end
        step();
        check_eq("t2_done_drop", {15'd0, done}, 16'd0);
        check_eq("t2_alarm", {15'd0, alarm}, 16'd1);
        pulse_start();
        pulse_pause();
        check_eq("t2_ignore_sp", {14'd0, state}, 16'd3);
        check_eq("t2_alarm_hold", {15'd0, alarm}, 16'd1);
        pulse_clear();
        check_eq("t2_clr_state", {14'd0, state}, 16'd0);
        check_eq("t2_clr_alarm", {15'd0, alarm}, 16'd0);

        // 3: borrow chain
        load_min = 8'h01; load_sec = 8'h00;
        step();
        pulse_start();
        repeat (4) step();
        check_eq("t3_0100_dec", {min_bcd, sec_bcd}, 16'h0059);
        pulse_clear();
        load_min = 8'h10;
        step();
        pulse_start();
        repeat (4) step();
        check_eq("t3_1000_dec", {min_bcd, sec_bcd}, 16'h0959);
        pulse_clear();

        // 4: pause keeps the partial second
        load_min = 8'h00; load_sec = 8'h05;
        step();
        pulse_start();
        step();
        pulse_pause();
        check_eq("t4_paused", {14'd0, state}, 16'd2);
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq($sformatf("t4_hold%0d", k), {7'd0, tick, sec_bcd}, 16'h0005);
        end
        pulse_start();
        check_eq("t4_resume", {7'd0, tick, 6'd0, state}, 16'h0001);
        check_eq("t4_resume_sec", {8'd0, sec_bcd}, 16'h05);
        step();
        check_eq("t4_tick", {15'd0, tick}, 16'd1);
        step();
        check_eq("t4_sec", {8'd0, sec_bcd}, 16'h04);
        pulse_clear();

        // 5: priority, zero load, sanitising
        load_sec = 8'h05;
        step();
        pulse_start();
        repeat (3) step();
        check_eq("t5_tick_pre", {15'd0, tick}, 16'd1);
        clear = 1'b1; pause = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; pause = 1'b0; start = 1'b0;
        check_eq("t5_cps_state", {14'd0, state}, 16'd0);
        check_eq("t5_cps_nodec", {8'd0, sec_bcd}, 16'h05);
        load_min = 8'hAF; load_sec = 8'h7A;
        step();
        check_eq("t5_sanit", {min_bcd, sec_bcd}, 16'h9959);
        load_min = 8'h00; load_sec = 8'h00;
        step();
        pulse_start();
        step();
        check_eq("t5_zero_start", {14'd0, state}, 16'd0);

        // 6: async reset mid-run at 00:02, prescaler 3
        load_sec = 8'h03;
        step();
        pulse_start();
        repeat (7) step();
        check_eq("t6_pre_sec", {8'd0, sec_bcd}, 16'h02);
        check_eq("t6_pre_tick", {15'd0, tick}, 16'd1);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_outs", {min_bcd, sec_bcd}, 16'h0000);
        check_eq("t6_rst_flags", {12'd0, state, tick, done}, 16'd0);
        step();
        check_eq("t6_rst_nodone", {14'd0, done, alarm}, 16'd0);
        reset = 1'b1;
        step();
        check_eq("t6_rel_state", {14'd0, state}, 16'd0);
        check_eq("t6_rel_preview", {min_bcd, sec_bcd}, 16'h0003);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Mm:ss countdown timer controller for the board-level timekeeping path. It owns a gated 1 s tick prescaler on the system clock and sequences it through load, run, pause and expiry. It keeps the remaining time as four BCD digits for the seven-segment display driver and raises an alarm at 00:00. Control inputs arrive as single-cycle, already-debounced pulses in the clock domain.

Parameters:
TICK_DIV, 50000000, clock cycles per 1 s tick; minimum 2; benches use 4.
CNT_W, 32, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  1-cycle pulse: begin from IDLE, or resume from PAUSE.
pause  input  1  1-cycle pulse: suspend countdown.
clear  input  1  1-cycle pulse: abort or acknowledge, return to IDLE.
load_min  input  8  preset minutes, BCD {tens,units}.
load_sec  input  8  preset seconds, BCD {tens,units}.
min_bcd  output  8  remaining minutes, BCD.
sec_bcd  output  8  remaining seconds, BCD.
state  output  2  0 IDLE, 1 RUN, 2 PAUSE, 3 EXPIRED.
tick  output  1  1-cycle strobe on each decrement.
done  output  1  1-cycle pulse on entering EXPIRED.
alarm  output  1  high while in EXPIRED.

Behaviour:
- Reset (async, reset=0): state IDLE; prescaler 0; min_bcd, sec_bcd, tick, done and alarm all 0.
- Load sanitising: any units digit >9 becomes 9. Seconds tens >5 becomes 5. Minutes tens >9 becomes 9.
- Input priority in the same cycle: clear > pause > start.
- IDLE:
  - min_bcd/sec_bcd follow the sanitised load values every cycle, giving a 1-cycle preview latency.
  - On start with a nonzero sanitised load: latch the digits, set prescaler to 0, go to RUN.
  - On start with a sanitised load of 00:00: ignore it and stay in IDLE.
- RUN:
  - The prescaler counts up every cycle. When it equals TICK_DIV-1 it wraps to 0 and tick=1 for that cycle.
  - The first tick occurs TICK_DIV cycles after the start edge.
  - Decrement on tick, as a BCD borrow chain:
    - sec units 0 -> 9 with a borrow into sec tens.
    - sec tens 0 -> 5 with a borrow into the minutes.
    - min units 0 -> 9 with a borrow into min tens.
    - A minutes value of 00 is never borrowed from, because EXPIRED is entered first.
  - A tick that produces 00:00 moves the state to EXPIRED on the same edge. done pulses for 1 cycle and alarm goes high.
  - pause -> PAUSE; the prescaler holds its value.
  - clear -> IDLE.
- PAUSE:
  - Digits and prescaler are frozen and tick=0.
  - start -> RUN. The prescaler resumes from its held value, so the partial second is preserved.
  - clear -> IDLE.
- EXPIRED:
  - Digits stay at 00:00.
  - start and pause are ignored.
  - clear -> IDLE; alarm drops on the same edge.
- Simultaneous tick and pause: the decrement is applied, then the state becomes PAUSE. If that decrement reaches 00:00, EXPIRED wins over PAUSE.
- Simultaneous tick and clear: clear wins, no decrement is applied and tick still strobes. The state becomes IDLE and the digits show the load preview on the next cycle.
- Async reset mid-RUN: everything returns to its reset values immediately; no done pulse is issued.
- All outputs are registered except tick, which is decoded from prescaler==TICK_DIV-1 gated with state==RUN.

Decomposition:
- Package timer_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRED;
  - digit limits SEC_TENS_MAX=5 and DIGIT_MAX=9;
  - the BCD sanitise and decrement functions.
- Sub-module tick_gen holds the prescaler: parameters TICK_DIV and CNT_W; inputs en and sync clr; output tick.
- The top level holds the FSM and the four BCD digit registers.

Test Plan:
1. Reset held, then released; pulse nothing -> state=0, min_bcd=0x00, sec_bcd=0x00, done=0, alarm=0.
2. TICK_DIV=4, load 00:03, start at cycle 0 -> tick at cycles 4, 8, 12; sec_bcd goes 02, 01, 00; state=3 at cycle 12; done high exactly 1 cycle; alarm stays high until clear.
3. Load 01:00, start, one tick -> min_bcd=0x00, sec_bcd=0x59. Load 10:00, one tick -> 09:59.
4. Load 00:05, start, pause at cycle 2. Hold 20 cycles with no tick and display 05. Start again -> next tick 2 cycles after resume, showing 04.
5. In RUN, clear, pause and start in the same cycle -> IDLE, no decrement. A start with load 00:00 leaves the state at IDLE. A load_sec of 0x7A previews as 0x59.
6. reset asserted mid-RUN at 00:02 with prescaler at 3 -> outputs zero immediately, no done pulse. After release the state is IDLE and the display previews the load value.
